ps2_rx: RTL and testbench

Synthesizable PS/2 device-to-host receiver for the FPGA side of the keyboard interface. It oversamples the open-collector PS/2 clock and data lines and filters glitches. It decodes 11-bit frames: start 0, eight data bits LSB first, odd parity, stop 1. Each good byte is presented to the keyboard decoder as a single-cycle strobe, and it is the counterpart of the keyboard behavioural model used in simulation.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_rx_filter.sv | 59 +++++
 rtl/ps2_rx.sv | 175 +++++++++++++++++
 tb/tb_ps2_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver state encoding and the
// odd-parity rule. Intended to be reused by a future transmitter.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit contain an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// Two-flop synchronizer followed by a saturating glitch filter for one raw
// PS/2 line. The filtered output only changes after FILTER_LEN consecutive
// synchronized samples disagree with it. Everything resets to 1 (idle-high).
module ps2_rx_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [7:0] CNT_MAX = 8'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Bring the asynchronous line into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing samples; flip on the FILTER_LEN-th one.
    always_comb begin
        cnt_d  = 8'd0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= 8'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filtered lines, registered falling-edge
// detector, frame FSM (start, 8 data LSB first, odd parity, stop) and an
// optional inter-edge watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

    logic       clk_f;
    logic       data_f;
    logic       clk_prev_q;
    logic       fall_q;
    logic       bit_q;
    logic       timeout_hit;

    ps2_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (ps2_clk),
        .filt_o (clk_f)
    );

    ps2_rx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (ps2_data),
        .filt_o (data_f)
    );

    // Registered falling-edge detect on the filtered clock, with the data bit
    // captured alongside so the FSM sees both on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_prev_q <= clk_f;
            fall_q     <= clk_prev_q & ~clk_f;
            bit_q      <= data_f;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;

    assign timeout_hit = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts clocks since the last edge while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (fall_q || state_q == ST_IDLE) begin
            wdog_q <= '0;
        end else if (!timeout_hit) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    // No watchdog in this build; the parameter is accepted but inert.
    localparam logic TIMEOUT_ZERO = (TIMEOUT_CYCLES == 0);
    assign timeout_hit = TIMEOUT_ZERO & 1'b0;
`endif

    // Frame FSM next-state and outcome decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall_q && !bit_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_d = {bit_q, shift_q[7:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    parity_d = bit_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    state_d = ST_IDLE;
                    if (!bit_q) begin
                        ferr_d = 1'b1;
                    end else if (ps2_parity_ok(shift_q, parity_q)) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned; a real edge on the same cycle takes priority.
        if (!fall_q && timeout_hit && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end
    end

    // FSM, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: a keyboard-like driver sends frames, the
// expected outcome of each frame is queued, and a monitor pops and compares
// whenever the receiver pulses valid, parity_err or frame_err.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int HALF = 20;      // PS/2 half period in system clocks
    localparam int TMO  = 200;     // watchdog length used in this bench

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] model_data = 8'd0;

    ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: outcome from frame content, in plain arithmetic.
    task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        int ones;
        ones = $countones(d) + int'(par);
        if (stop == 1'b0) begin
            e.kind = K_FERR;
        end else if (ones % 2 == 1) begin
            e.kind = K_VALID;
            model_data = d;
        end else begin
            e.kind = K_PERR;
        end
        e.data = model_data;
        exp_q.push_back(e);
    endtask

    // Drive the first nbits of a frame; glitch adds a 5-clock low pulse on
    // ps2_clk in the high phase of bit 5.
    task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 5) begin
                repeat (5) @(posedge clk);
                ps2_clk = 1'b0;
                repeat (5) @(posedge clk);
                ps2_clk = 1'b1;
                repeat (HALF - 10) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit flip, input logic stop, input bit glitch);
        logic par;
        par = ~(^d) ^ flip;
        expect_frame(d, par, stop);
        $display("send byte=%02h parity=%0b stop=%0b glitch=%0b", d, par, stop, glitch);
        drive_bits({stop, par, d, 1'b0}, PS2_FRAME_BITS, glitch);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("busy_after_frame", busy, 1'b0);
    endtask

    task automatic wait_drained;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: every outcome pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid || parity_err || frame_err) begin
                $display("rx valid=%0b perr=%0b ferr=%0b data=%02h", valid, parity_err, frame_err, data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_outcome actual=%0b%0b%0b required=none", valid, parity_err, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_kind", {valid, parity_err, frame_err}, e.kind);
                    chk("outcome_data", data, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [10:0] fr;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_data", data, 8'h00);
        chk("reset_flags", {valid, parity_err, frame_err, busy}, 4'b0000);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Directed frames.
        send(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("data_1c", data, 8'h1C);
        send(8'hF0, 1'b1, 1'b1, 1'b0);
        chk("data_hold_perr", data, 8'h1C);
        send(8'h55, 1'b0, 1'b0, 1'b0);
        chk("data_hold_ferr", data, 8'h1C);
        send(8'hAA, 1'b0, 1'b1, 1'b0);
        chk("data_aa", data, 8'hAA);

        // Glitch while idle, then a frame carrying a mid-frame glitch.
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_glitch_busy", busy, 1'b0);
        send(8'h29, 1'b0, 1'b1, 1'b1);
        chk("data_29", data, 8'h29);

        // Randomized frames, including back-to-back sends.
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 1'b0);
        end
        wait_drained();

        // Truncated frame: start plus 4 data bits, then silence.
        $display("abort after start plus 4 bits");
        fr = {1'b1, 1'b0, 8'h0F, 1'b0};
`ifdef PS2_RX_TIMEOUT_EN
        begin
            exp_t e;
            e.kind = K_FERR;
            e.data = model_data;
            exp_q.push_back(e);
        end
`endif
        drive_bits(fr, 5, 1'b0);
        @(negedge clk);
`ifndef PS2_RX_TIMEOUT_EN
        chk("abort_busy_mid", busy, 1'b1);
`endif
        repeat (2 * TMO) @(posedge clk);
        @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
        chk("abort_busy_after_timeout", busy, 1'b0);
        wait_drained();
`else
        chk("abort_busy_stuck", busy, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        model_data = 8'd0;
        repeat (5) @(posedge clk);
`endif
        send(8'h12, 1'b0, 1'b1, 1'b0);
        chk("data_12", data, 8'h12);

        // Reset mid-frame after bit 3.
        $display("reset mid-frame");
        fr = {1'b1, 1'b1, 8'h1C, 1'b0};
        drive_bits(fr, 4, 1'b0);
        @(negedge clk);
        chk("busy_before_reset", busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_mid_data", data, 8'h00);
        chk("reset_mid_flags", {valid, parity_err, frame_err, busy}, 4'b0000);
        model_data = 8'd0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        send(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("data_1c_after_reset", data, 8'h1C);

        wait_drained();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
